run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//   Run-sequencing controller for the 9-bit-instruction single-cycle core.
//   Owns Start/Ack handshake with the host bench, loads per-program entry address
//   into the program counter, gates PC advance, counts executed cycles, enforces a
//   watchdog. Sits between bench pins (Start, Ack) and the fetch stage / control decoder halt flag.
// PARAMETERS
//   AW        10      program-counter / instruction-address width
//   CW        16      cycle-counter width
//   NPROG     3       number of programs in instruction ROM, selected round-robin
//   MAX_CYC   16'hFFF0 watchdog limit in RUN cycles (must be < 2**CW)
// PORTS
//   Clk         in   1    clock, posedge
//   Reset       in   1    asynchronous reset, active high
//   Start       in   1    bench start request; level, held high during setup
//   Halt        in   1    done flag from control decoder (halt instruction decoded)
//   PcEn        out  1    PC may advance/branch this cycle
//   PcLoad      out  1    PC loads PcLoadAddr on next posedge
//   PcLoadAddr  out  AW   entry address of program ProgIdx
//   ProgIdx     out  2    index of current/next program, 0..NPROG-1
//   CycleCt     out  CW   RUN cycles of last/current run (saturating)
//   Timeout     out  1    last run ended by watchdog, not Halt
//   Ack         out  1    run complete; to bench
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, PcEn=0, PcLoad=0, Ack=0, Timeout=0,
//     CycleCt=0, ProgIdx=0. Reset mid-RUN aborts run; no Ack produced.
//   States IDLE, ARM, RUN, DONE; registered, encoded in package enum.
//   IDLE: all outputs low except ProgIdx/PcLoadAddr. Start=1 -> ARM.
//   ARM : PcLoad=1, PcEn=0, Ack=0. CycleCt cleared, Timeout cleared on entry.
//         Stay while Start=1; Start=0 -> RUN (PC holds entry addr on first RUN cycle).
//   RUN : PcEn = ~Halt (combinational, so halt instruction does not advance PC).
//         CycleCt += 1 each RUN cycle, saturates at all-ones.
//         Priority: Start=1 -> ARM (abort, ProgIdx unchanged, no Ack);
//         else Halt=1 -> DONE; else CycleCt==MAX_CYC-1 -> DONE with Timeout=1.
//         Halt and watchdog same cycle: Halt wins, Timeout=0.
//   DONE: Ack=1 (registered: first high the cycle after Halt sampled), PcEn=0,
//         CycleCt/Timeout frozen. Start=1 -> ARM, Ack low from ARM's first cycle.
//   ProgIdx advances on RUN->DONE only: wraps NPROG-1 -> 0. Abort does not advance.
//   PcLoadAddr = START_ADDR[ProgIdx] combinational from package table.
//   Start glitches shorter than one cycle undefined; Start sampled only at posedge.
//   Halt ignored outside RUN.
// STRUCTURE
//   run_ctrl_pkg: state_t enum {IDLE,ARM,RUN,DONE}; START_ADDR[NPROG] localparam
//     table (AW bits each, default 0, 'h100, 'h200); NPROG constant shared with InstROM layout.
//   Sub-module sat_counter #(W) (Clk, Reset, Clr, En, Q): async-reset saturating counter
//     used for CycleCt. FSM, ProgIdx register, output decode in run_ctrl.
// TESTING
//   Reset then Start high 3 cyc, low: PcLoad=1 for 3 cyc, PcLoadAddr=0, RUN begins, PcEn=1.
//   Halt after 20 RUN cyc: PcEn=0 same cyc, Ack=1 next cyc, CycleCt=20, Timeout=0, ProgIdx=1.
//   Three full runs: PcLoadAddr 'h000, 'h100, 'h200, then ProgIdx wraps to 0.
//   Hold Halt=0 with MAX_CYC=8: DONE after 8 cyc, Timeout=1, Ack=1, CycleCt=8.
//   Start=1 mid-RUN at cyc 5: ARM, no Ack, ProgIdx unchanged, CycleCt=0 in ARM.
//   Reset asserted mid-RUN between edges: all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: run-sequencer state encoding and per-program entry table shared with the InstROM layout
package run_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  localparam int NPROG = 3;
  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] START_ADDR [NPROG] = '{10'h000, 10'h100, 10'h200};
endpackage

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: async-reset up counter that sticks at all-ones, with synchronous clear over enable
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         En,
  output logic [W-1:0] Q
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) Q <= '0;
    else if (Clr) Q <= '0;
    else if (En && Q != '1) Q <= Q + 1'b1;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: Start/Ack run sequencer loading program entry addresses, gating PC advance, counting and watchdogging runs
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          AW      = ADDR_W,
  parameter int          CW      = 16,
  parameter logic [CW-1:0] MAX_CYC = 16'hFFF0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  output logic          PcEn,
  output logic          PcLoad,
  output logic [AW-1:0] PcLoadAddr,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] CycleCt,
  output logic          Timeout,
  output logic          Ack
);
  state_t state;
  logic [1:0] nextIdx;
  logic watchdog;
  assign nextIdx = ProgIdx == 2'(NPROG - 1) ? 2'd0 : ProgIdx + 2'd1;
  assign watchdog = CycleCt == MAX_CYC - 1'b1;
  assign PcEn = state == RUN && !Halt;
  assign PcLoadAddr = AW'(START_ADDR[ProgIdx]);
  // every state heads to ARM on Start, so Start alone clears the count on ARM entry
  sat_counter #(.W(CW)) cycleCounter (
    .Clk(Clk),
    .Reset(Reset),
    .Clr(Start),
    .En(state == RUN),
    .Q(CycleCt)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      PcLoad <= 1'b0;
      Ack <= 1'b0;
      Timeout <= 1'b0;
      ProgIdx <= 2'd0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state <= ARM;
          PcLoad <= 1'b1;
          Timeout <= 1'b0;
        end
        ARM: if (!Start) begin
          state <= RUN;
          PcLoad <= 1'b0;
        end
        RUN: if (Start) begin
          state <= ARM;
          PcLoad <= 1'b1;
          Timeout <= 1'b0;
        end else if (Halt || watchdog) begin
          state <= DONE;
          Ack <= 1'b1;
          Timeout <= !Halt;
          ProgIdx <= nextIdx;
        end
        DONE: if (Start) begin
          state <= ARM;
          PcLoad <= 1'b1;
          Ack <= 1'b0;
          Timeout <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboarded bench for run_ctrl; expected run results queued at launch and retired on Ack
module tb_run_ctrl;
  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Halt = 1'b0, wStart = 1'b0, wHalt = 1'b0;
  logic PcEn, PcLoad, Ack, Timeout, wPcEn, wPcLoad, wAck, wTimeout;
  logic [9:0] PcLoadAddr, wPcLoadAddr;
  logic [1:0] ProgIdx, wProgIdx;
  logic [15:0] CycleCt, wCycleCt;
  int nChecks = 0, nFails = 0, nPush = 0, nPops = 0, modelIdx = 0;
  typedef struct {int cyc; int to; int idx;} runResult;
  runResult sb[$];

  run_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .PcEn(PcEn), .PcLoad(PcLoad),
    .PcLoadAddr(PcLoadAddr), .ProgIdx(ProgIdx), .CycleCt(CycleCt), .Timeout(Timeout), .Ack(Ack)
  );
  run_ctrl #(.MAX_CYC(16'd8)) wdut (
    .Clk(Clk), .Reset(Reset), .Start(wStart), .Halt(wHalt), .PcEn(wPcEn), .PcLoad(wPcLoad),
    .PcLoadAddr(wPcLoadAddr), .ProgIdx(wProgIdx), .CycleCt(wCycleCt), .Timeout(wTimeout), .Ack(wAck)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  always @(posedge Ack) begin : ackMon
    runResult r;
    #1;
    if (sb.size() == 0) check("unexpectedAck", 32'd1, 32'd0);
    else begin
      r = sb.pop_front();
      nPops++;
      check("ackCycleCt", CycleCt, r.cyc);
      check("ackTimeout", Timeout, r.to);
      check("ackProgIdx", ProgIdx, r.idx);
    end
  end

  task automatic arm(input int cycles);
    Start = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick;
      check("armPcLoad", PcLoad, 1);
      check("armPcEn", PcEn, 0);
      check("armAck", Ack, 0);
      check("armCycleCt", CycleCt, 0);
      check("armTimeout", Timeout, 0);
      check("armAddr", PcLoadAddr, modelIdx * 'h100);
    end
    Start = 1'b0;
  endtask

  task automatic runBody(input int haltAt);
    sb.push_back('{haltAt, 0, (modelIdx + 1) % 3});
    nPush++;
    for (int k = 1; k <= haltAt; k++) begin
      tick;
      check("runPcLoad", PcLoad, 0);
      check("runCycleCt", CycleCt, k - 1);
      if (k == haltAt) begin
        Halt = 1'b1;
        #1;
        check("haltPcEn", PcEn, 0);
      end else check("runPcEn", PcEn, 1);
    end
    tick;
    Halt = 1'b0;
    modelIdx = (modelIdx + 1) % 3;
    check("doneAck", Ack, 1);
    check("donePcEn", PcEn, 0);
    tick;
    check("holdAck", Ack, 1);
    check("holdCycleCt", CycleCt, haltAt);
  endtask

  task automatic runProgram(input int haltAt);
    arm(3);
    runBody(haltAt);
  endtask

  initial begin
    #200000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    tick;
    tick;
    check("rstPcEn", PcEn, 0);
    check("rstPcLoad", PcLoad, 0);
    check("rstAck", Ack, 0);
    check("rstTimeout", Timeout, 0);
    check("rstCycleCt", CycleCt, 0);
    check("rstProgIdx", ProgIdx, 0);
    Reset = 1'b0;
    tick;
    check("idlePcLoad", PcLoad, 0);
    // watchdog instance: limit of 8 RUN cycles
    wStart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("wArmPcLoad", wPcLoad, 1);
    end
    wStart = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      check("wRunPcEn", wPcEn, 1);
      check("wRunAck", wAck, 0);
      check("wRunCycleCt", wCycleCt, k - 1);
    end
    tick;
    check("wdogAck", wAck, 1);
    check("wdogTimeout", wTimeout, 1);
    check("wdogCycleCt", wCycleCt, 8);
    check("wdogPcEn", wPcEn, 0);
    check("wdogProgIdx", wProgIdx, 1);
    wStart = 1'b1;
    tick;
    check("wRearmTimeout", wTimeout, 0);
    check("wRearmAck", wAck, 0);
    check("wRearmCycleCt", wCycleCt, 0);
    tick;
    wStart = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (k == 8) wHalt = 1'b1;
    end
    tick;
    wHalt = 1'b0;
    check("haltWinsTimeout", wTimeout, 0);
    check("haltWinsAck", wAck, 1);
    check("haltWinsCycleCt", wCycleCt, 8);
    check("haltWinsProgIdx", wProgIdx, 2);
    // three full runs through the program table, then wrap
    runProgram(20);
    runProgram(3);
    runProgram(1);
    check("wrapProgIdx", ProgIdx, 0);
    check("wrapAddr", PcLoadAddr, 0);
    // abort mid-run keeps the program index and produces no Ack
    arm(3);
    for (int k = 1; k <= 5; k++) begin
      tick;
      check("abortRunCycleCt", CycleCt, k - 1);
    end
    Start = 1'b1;
    tick;
    check("abortPcLoad", PcLoad, 1);
    check("abortAck", Ack, 0);
    check("abortCycleCt", CycleCt, 0);
    check("abortProgIdx", ProgIdx, modelIdx);
    arm(1);
    runBody(7);
    // asynchronous reset between edges during RUN
    arm(2);
    for (int k = 0; k < 4; k++) tick;
    check("preRstPcEn", PcEn, 1);
    #2;
    Reset = 1'b1;
    #1;
    check("midRstPcEn", PcEn, 0);
    check("midRstPcLoad", PcLoad, 0);
    check("midRstAck", Ack, 0);
    check("midRstTimeout", Timeout, 0);
    check("midRstCycleCt", CycleCt, 0);
    check("midRstProgIdx", ProgIdx, 0);
    modelIdx = 0;
    tick;
    Reset = 1'b0;
    tick;
    tick;
    check("postRstIdle", PcLoad, 0);
    check("postRstAck", Ack, 0);
    runProgram(2);
    check("sbDrained", sb.size(), 0);
    check("ackCount", nPops, nPush);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
